gps_sample_packer: RTL and testbench
====================================

GPS_SAMPLE_PACKER -- requirements
Module: gps_sample_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, number of buffered 4-bit samples (power of two, 4..16).
REQ-002 SHALL have parameter MIN_GAP, default 6, MCU_CLK_25_000 cycles from one DATAREADY pulse to the next (minimum 5).
REQ-003 SHALL have ports: MCU_CLK_25_000  in  1  sole clock, all logic on its rising edge.
REQ-004 SHALL have ports: RESET_N  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: GPS_CLK  in  1  front-end sample clock, asynchronous to MCU_CLK_25_000.
REQ-006 SHALL have ports: GPS_I0, GPS_I1, GPS_Q0, GPS_Q1  in  1 each  front-end sample bits, valid at the GPS_CLK rising edge.
REQ-007 SHALL have ports: ENABLE  in  1  capture enable.
REQ-008 SHALL have ports: SMP_I0, SMP_I1, SMP_Q0, SMP_Q1  out  1 each  presented sample to the serializer.
REQ-009 SHALL have ports: DATAREADY  out  1  one-cycle pulse, new sample on SMP_*.
REQ-010 SHALL have ports: FIFO_LEVEL  out  clog2(FIFO_DEPTH)+1  entries held.
REQ-011 SHALL have ports: OVERFLOW  out  1  sticky, a sample was dropped.
REQ-012 SHALL have ports: DROP_COUNT  out  8  dropped samples, saturating.

Function
REQ-013 SHALL pass GPS_CLK and the four GPS bits through the same 2-flop synchronizer (s1, s2), then hold one more GPS_CLK stage s3.
REQ-014 SHALL form capture strobe = s2 & ~s3; the captured nibble is the s2 copy of {I0,I1,Q0,Q1}.
REQ-015 SHALL write the nibble into the FIFO on the edge after strobe when ENABLE=1 and the FIFO has room, or is full with a pop on that same edge.
REQ-016 SHALL, when a strobe finds the FIFO full with no pop, drop the nibble, set OVERFLOW and increment DROP_COUNT, holding it at 255.
REQ-017 SHALL ignore strobes while ENABLE=0; the FIFO keeps draining.
REQ-018 SHALL run an output FSM with states IDLE and GAP.
REQ-019 SHALL, in IDLE with FIFO non-empty, pop the FIFO, load SMP_*, pulse DATAREADY for exactly one cycle, load the gap counter with MIN_GAP-1 and enter GAP.
REQ-020 SHALL, in GAP, decrement the gap counter each cycle and return to IDLE when it reaches 0, so that pulses under a backlog are exactly MIN_GAP cycles apart.
REQ-021 SHALL hold SMP_* stable between pulses.
REQ-022 SHALL give an empty-FIFO latency of: GPS_CLK first sampled high at edge k -> FIFO write at k+2 -> DATAREADY and SMP_* valid after edge k+3.
REQ-023 SHALL keep FIFO_LEVEL unchanged on a simultaneous write and pop; it SHALL never exceed FIFO_DEPTH or wrap below 0.
REQ-024 SHALL wrap the FIFO pointers modulo FIFO_DEPTH.
REQ-025 SHALL treat an unreachable FSM encoding as IDLE on the next edge.

Reset
REQ-026 SHALL, with RESET_N low, asynchronously force: SMP_*=0, DATAREADY=0, FIFO_LEVEL=0, OVERFLOW=0, DROP_COUNT=0, pointers=0, gap counter=0, state=IDLE.
REQ-027 SHALL reset the GPS_CLK synchronizer stages s1/s2/s3 to 1, so that releasing reset while GPS_CLK is high produces no spurious strobe.
REQ-028 SHALL discard FIFO contents on reset mid-operation, and SHALL produce no DATAREADY until a new GPS_CLK rising edge completes the latency in REQ-022.
REQ-029 SHALL clear OVERFLOW and DROP_COUNT only by reset.

Structure
REQ-030 SHALL take FIFO_DEPTH and MIN_GAP defaults and the FSM state encodings from the shared gps_cpld_defs.vh include.
REQ-031 SHALL instantiate one sub-module, sample_fifo: 4 bits wide, FIFO_DEPTH deep, with push, pop, full, empty and level, asynchronous active-low reset.
REQ-032 SHALL keep the synchronizer, edge detect, drop counter and output FSM in gps_sample_packer.

Verification
REQ-033 SHALL cover single sample: GPS_CLK rise with nibble 1010, ENABLE=1 -> one DATAREADY pulse 4 edges later with SMP_*=1010 and FIFO_LEVEL back at 0.
REQ-034 SHALL cover backlog: a burst of 5 GPS_CLK edges spaced 2 cycles apart -> 5 pulses exactly 6 cycles apart, in order, with FIFO_LEVEL peaking at 4 or less.
REQ-035 SHALL cover overflow: GPS_CLK at 1 edge per 3 cycles for 60 cycles -> OVERFLOW=1, DROP_COUNT equal to the model count, no duplicated or reordered samples.
REQ-036 SHALL cover saturation: more than 300 drops -> DROP_COUNT=255 and held there.
REQ-037 SHALL cover ENABLE low with 3 queued -> no new writes and exactly 3 further pulses.
REQ-038 SHALL cover reset: RESET_N low mid-GAP with level 4 -> all outputs 0 immediately, and no pulse after release with GPS_CLK held high.

Source files
------------

// File: rtl/gps_sample_packer_pkg.sv
// rtl/gps_sample_packer_pkg.sv - shared defaults and output FSM encoding for the GPS sample packer
package gps_sample_packer_pkg;

  localparam int FIFO_DEPTH_DEFAULT = 8;
  localparam int MIN_GAP_DEFAULT    = 6;
  localparam int NIBBLE_W           = 4;

  // Sync word is {GPS_CLK, I0, I1, Q0, Q1}; the clock bit resets high so a
  // reset release with GPS_CLK already high does not look like a rising edge.
  localparam logic [NIBBLE_W:0] SYNC_RESET = 5'b1_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b01,
    ST_GAP  = 2'b10
  } out_state_e;

endpackage

// File: rtl/gps_sample_packer_sample_fifo.sv
// rtl/gps_sample_packer_sample_fifo.sv - nibble FIFO with occupancy level
module sample_fifo
  import gps_sample_packer_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      push_i,
  input  logic [NIBBLE_W-1:0]       wdata_i,
  input  logic                      pop_i,
  output logic [NIBBLE_W-1:0]       rdata_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [$clog2(DEPTH):0]    level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [NIBBLE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]       level_q, level_d;
  logic                push_ok, pop_ok;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // A push into a full FIFO is only legal when the same edge frees a slot.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/gps_sample_packer.sv
// rtl/gps_sample_packer.sv - captures GPS front-end nibbles into a FIFO and paces them out with DATAREADY pulses
module gps_sample_packer
  import gps_sample_packer_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int MIN_GAP    = MIN_GAP_DEFAULT
) (
  input  logic                          MCU_CLK_25_000,
  input  logic                          RESET_N,
  input  logic                          GPS_CLK,
  input  logic                          GPS_I0,
  input  logic                          GPS_I1,
  input  logic                          GPS_Q0,
  input  logic                          GPS_Q1,
  input  logic                          ENABLE,
  output logic                          SMP_I0,
  output logic                          SMP_I1,
  output logic                          SMP_Q0,
  output logic                          SMP_Q1,
  output logic                          DATAREADY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic                          OVERFLOW,
  output logic [7:0]                    DROP_COUNT
);

  localparam int GW = $clog2(MIN_GAP);

  logic [NIBBLE_W:0]   sync1_q, sync2_q;
  logic                s3_q;
  logic                strobe, accept, push, pop, drop;
  logic                fifo_full, fifo_empty;
  logic [NIBBLE_W-1:0] fifo_rdata;
  out_state_e          state_q, state_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [NIBBLE_W-1:0] smp_q, smp_d;
  logic                dready_q;
  logic                overflow_q, overflow_d;
  logic [7:0]          drop_cnt_q, drop_cnt_d;

  always_ff @(posedge MCU_CLK_25_000 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= SYNC_RESET;
      sync2_q <= SYNC_RESET;
      s3_q    <= 1'b1;
    end else begin
      sync1_q <= {GPS_CLK, GPS_I0, GPS_I1, GPS_Q0, GPS_Q1};
      sync2_q <= sync1_q;
      s3_q    <= sync2_q[NIBBLE_W];
    end
  end

  assign strobe = sync2_q[NIBBLE_W] & ~s3_q;
  assign accept = strobe & ENABLE;
  assign pop    = (state_q == ST_IDLE) & ~fifo_empty;
  assign push   = accept & (~fifo_full | pop);
  assign drop   = accept & fifo_full & ~pop;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (MCU_CLK_25_000),
    .rst_n_i (RESET_N),
    .push_i  (push),
    .wdata_i (sync2_q[NIBBLE_W-1:0]),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (FIFO_LEVEL)
  );

  // Leaving GAP on the edge the counter hits zero puts pulses exactly MIN_GAP apart.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_GAP;
          gap_d   = GW'(MIN_GAP - 1);
        end
      end
      ST_GAP: begin
        if (gap_q <= GW'(1)) begin
          state_d = ST_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gap_d   = '0;
      end
    endcase
  end

  always_comb begin
    smp_d      = smp_q;
    overflow_d = overflow_q | drop;
    drop_cnt_d = drop_cnt_q;
    if (pop) smp_d = fifo_rdata;
    if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge MCU_CLK_25_000 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      gap_q      <= '0;
      smp_q      <= '0;
      dready_q   <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      smp_q      <= smp_d;
      dready_q   <= pop;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign {SMP_I0, SMP_I1, SMP_Q0, SMP_Q1} = smp_q;
  assign DATAREADY  = dready_q;
  assign OVERFLOW   = overflow_q;
  assign DROP_COUNT = drop_cnt_q;

endmodule

// File: tb/tb_gps_sample_packer.sv
// tb/tb_gps_sample_packer.sv - scoreboard bench for gps_sample_packer
module tb_gps_sample_packer;

  typedef struct {
    logic [3:0] nib;
    int         at;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       gps_clk = 1'b0;
  logic       i0 = 1'b0, i1 = 1'b0, q0 = 1'b0, q1 = 1'b0;
  logic       enable = 1'b0;
  logic       smp_i0, smp_i1, smp_q0, smp_q1;
  logic       dataready, overflow;
  logic [3:0] fifo_level;
  logic [7:0] drop_count;
  logic [3:0] smp;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   pulses = 0;
  int   max_level = 0;
  bit   sat_mode = 1'b0;

  gps_sample_packer dut (
    .MCU_CLK_25_000 (clk),
    .RESET_N        (rst_n),
    .GPS_CLK        (gps_clk),
    .GPS_I0         (i0),
    .GPS_I1         (i1),
    .GPS_Q0         (q0),
    .GPS_Q1         (q1),
    .ENABLE         (enable),
    .SMP_I0         (smp_i0),
    .SMP_I1         (smp_i1),
    .SMP_Q0         (smp_q0),
    .SMP_Q1         (smp_q1),
    .DATAREADY      (dataready),
    .FIFO_LEVEL     (fifo_level),
    .OVERFLOW       (overflow),
    .DROP_COUNT     (drop_count)
  );

  assign smp = {smp_i0, smp_i1, smp_q0, smp_q1};

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void check_le(input string name, input int act, input int limit);
    vectors++;
    if (act > limit) begin
      miscompares++;
      $display("FAIL %s: got %0d, required at most %0d", name, act, limit);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
      if (dataready) begin
        pulses = pulses + 1;
        if (sat_mode) begin
          check("sat_nibble", int'(smp), 6);
        end else if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pulse: got pulse with nibble %0d at cycle %0d, required none", smp, cyc);
        end else begin
          mon_e = sb.pop_front();
          check("nibble", int'(smp), int'(mon_e.nib));
          if (mon_e.at >= 0) check("pulse_cycle", cyc, mon_e.at);
        end
      end
    end
  end

  // Called on a falling edge; GPS_CLK is seen high at the next rising edge (cyc+1).
  task automatic gps_pulse(input logic [3:0] nib, input int period, input bit expect_it, input int at);
    exp_t e;
    {i0, i1, q0, q1} = nib;
    gps_clk = 1'b1;
    if (expect_it) begin
      e.nib = nib;
      e.at  = at;
      sb.push_back(e);
    end
    @(negedge clk);
    gps_clk = 1'b0;
    repeat (period - 1) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || fifo_level != 4'd0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained_level"}, int'(fifo_level), 0);
    check({name, "_drained_queue"}, sb.size(), 0);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #(40 * 20000);
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, base;
    logic [3:0] nibs [6];
    nibs[0] = 4'h3; nibs[1] = 4'hC; nibs[2] = 4'h5;
    nibs[3] = 4'h9; nibs[4] = 4'hE; nibs[5] = 4'h1;

    repeat (3) @(negedge clk);
    check("rst_smp", int'(smp), 0);
    check("rst_dataready", int'(dataready), 0);
    check("rst_level", int'(fifo_level), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_drop", int'(drop_count), 0);
    rst_n  = 1'b1;
    enable = 1'b1;
    repeat (4) @(negedge clk);

    // single sample: pulse after edge k+3
    k = cyc + 1;
    gps_pulse(4'b1010, 1, 1'b1, k + 3);
    repeat (3) @(negedge clk);
    check("single_dataready", int'(dataready), 1);
    check("single_level", int'(fifo_level), 0);
    @(negedge clk);
    check("single_one_cycle", int'(dataready), 0);
    check("single_smp_held", int'(smp), 4'b1010);
    drain("single");

    // backlog of 5 strobes 2 cycles apart
    max_level = 0;
    base = pulses;
    k = cyc + 1;
    for (int j = 0; j < 5; j++) gps_pulse(nibs[j], 2, 1'b1, k + 3 + 6 * j);
    drain("backlog");
    check("backlog_pulses", pulses - base, 5);
    check_le("backlog_peak", max_level, 4);

    // overflow: 20 strobes 3 cycles apart, strobes 16 and 18 find a full FIFO
    max_level = 0;
    base = pulses;
    for (int n = 0; n < 20; n++) gps_pulse(4'((n * 5 + 1) % 16), 3, !(n == 16 || n == 18), -1);
    check("ovf_flag", int'(overflow), 1);
    check("ovf_drops", int'(drop_count), 2);
    drain("ovf");
    check("ovf_pulses", pulses - base, 18);
    check("ovf_peak", max_level, 8);

    // ENABLE low with 3 queued
    k = cyc + 1;
    for (int j = 0; j < 4; j++) gps_pulse(nibs[j], 2, 1'b1, k + 3 + 6 * j);
    @(negedge clk);
    check("en_queued", int'(fifo_level), 3);
    enable    = 1'b0;
    base      = pulses;
    max_level = 0;
    for (int j = 0; j < 3; j++) gps_pulse(4'hF, 2, 1'b0, -1);
    drain("en");
    check("en_pulses", pulses - base, 3);
    check_le("en_no_writes", max_level, 3);
    enable = 1'b1;

    // saturation
    sat_mode = 1'b1;
    repeat (700) gps_pulse(4'h6, 2, 1'b0, -1);
    check("sat_count", int'(drop_count), 255);
    check("sat_overflow", int'(overflow), 1);
    repeat (100) gps_pulse(4'h6, 2, 1'b0, -1);
    check("sat_held", int'(drop_count), 255);
    drain("sat");
    sat_mode = 1'b0;

    // reset mid-GAP with level 4
    base = pulses;
    k = cyc + 1;
    for (int j = 0; j < 6; j++) gps_pulse(nibs[j], 2, j < 2, k + 3 + 6 * j);
    gps_clk = 1'b1;
    @(negedge clk);
    check("rst_pre_level", int'(fifo_level), 4);
    rst_n = 1'b0;
    #1;
    check("rstmid_smp", int'(smp), 0);
    check("rstmid_dataready", int'(dataready), 0);
    check("rstmid_level", int'(fifo_level), 0);
    check("rstmid_overflow", int'(overflow), 0);
    check("rstmid_drop", int'(drop_count), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("rstmid_pulses", pulses - base, 2);
    check("rstmid_level_after", int'(fifo_level), 0);

    // fresh GPS_CLK rise after reset still follows the normal latency
    gps_clk = 1'b0;
    repeat (3) @(negedge clk);
    k = cyc + 1;
    gps_pulse(4'b0101, 1, 1'b1, k + 3);
    drain("post_rst");
    check("post_rst_overflow", int'(overflow), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
